// File: rtl/seq_divider.sv
// Radix-2 sequential restoring divider: Q = A / B, R = A % B, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero,
    output logic [7:0]       state
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_bmag;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_qsr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dbz;

    logic             r_busy;
    logic             r_done;
    logic [7:0]       r_state_dbg;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_div_by_zero;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_sign_q;
    logic             w_sign_r;
    logic             w_b_zero;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

`ifdef DIV_SIGNED_EN
    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return {WIDTH{1'b0}} - v;
    endfunction

    // The most negative value maps onto 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? f_neg(v) : v;
    endfunction

    assign w_a_mag  = f_mag(r_a);
    assign w_b_mag  = f_mag(r_b);
    assign w_sign_q = r_a[WIDTH-1] ^ r_b[WIDTH-1];
    assign w_sign_r = r_a[WIDTH-1];
    assign w_q_fix  = r_sign_q ? f_neg(r_qsr) : r_qsr;
    assign w_r_fix  = r_sign_r ? f_neg(r_p) : r_p;
`else
    assign w_a_mag  = r_a;
    assign w_b_mag  = r_b;
    assign w_sign_q = 1'b0;
    assign w_sign_r = 1'b0;
    assign w_q_fix  = r_qsr;
    assign w_r_fix  = r_p;
`endif

    assign w_b_zero   = (r_b == {WIDTH{1'b0}});
    assign w_shift    = {r_p, r_qsr[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_bmag});
    // A successful trial subtraction always leaves less than |B|, so WIDTH bits suffice.
    assign w_rem_next = w_ge ? WIDTH'(w_shift - {1'b0, r_bmag}) : w_shift[WIDTH-1:0];

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (valid) begin
                    w_next = S_LOAD;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_LOAD: begin
                if (w_b_zero) begin
                    w_next = S_FIX;
                end else begin
                    w_next = S_ITER;
                end
            end
            S_ITER: begin
                if (r_cnt == CNT_LAST) begin
                    w_next = S_FIX;
                end else begin
                    w_next = S_ITER;
                end
            end
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register with registered status outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_state_dbg <= 8'h00;
        end else begin
            r_state     <= w_next;
            r_busy      <= (w_next != S_IDLE);
            r_done      <= (w_next == S_DONE);
            r_state_dbg <= {5'b00000, w_next};
        end
    end

    // Operand latch, magnitude load and restoring iteration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_bmag   <= {WIDTH{1'b0}};
            r_p      <= {WIDTH{1'b0}};
            r_qsr    <= {WIDTH{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        r_a <= A;
                        r_b <= B;
                    end
                end
                S_LOAD: begin
                    r_p      <= {WIDTH{1'b0}};
                    r_qsr    <= w_a_mag;
                    r_bmag   <= w_b_mag;
                    r_sign_q <= w_sign_q;
                    r_sign_r <= w_sign_r;
                    r_dbz    <= w_b_zero;
                    r_cnt    <= {CNT_W{1'b0}};
                end
                S_ITER: begin
                    r_p   <= w_rem_next;
                    r_qsr <= {r_qsr[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers, written only in FIX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q           <= {WIDTH{1'b0}};
            r_r           <= {WIDTH{1'b0}};
            r_div_by_zero <= 1'b0;
        end else if (r_state == S_FIX) begin
            if (r_dbz) begin
                r_q           <= {WIDTH{1'b1}};
                r_r           <= r_a;
                r_div_by_zero <= 1'b1;
            end else begin
                r_q           <= w_q_fix;
                r_r           <= w_r_fix;
                r_div_by_zero <= 1'b0;
            end
        end else begin
            r_q           <= r_q;
            r_r           <= r_r;
            r_div_by_zero <= r_div_by_zero;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign Q           = r_q;
    assign R           = r_r;
    assign div_by_zero = r_div_by_zero;
    assign state       = r_state_dbg;

endmodule
